// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, 8N1 framing (optional even parity bit), LSB first.
// Latency: o_Tx falls on the accepting edge; o_fDone rises 10*CLKS_PER_BIT cycles later (11* with parity).
// Backpressure: a request is accepted only in IDLE; i_fStart while o_fBusy is high is dropped, never queued.
//
// Ports:
//   i_Clk     system clock, rising edge
//   i_Rst     synchronous active-high reset
//   i_fStart  send request, sampled only in IDLE
//   i_Data    byte to send, captured on the accepting edge
//   o_Tx      registered serial line, idles high
//   o_fBusy   high from the accepting edge until the frame ends
//   o_fDone   one-cycle registered pulse at the end of the stop bit
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit.

module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fStart,
  input  logic [7:0] i_Data,
  output logic       o_Tx,
  output logic       o_fBusy,
  output logic       o_fDone
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q,   state_nxt;
  logic [CNT_W-1:0] cnt_q,     cnt_nxt;
  logic [2:0]       bit_idx_q, bit_idx_nxt;
  logic [7:0]       shift_q,   shift_nxt;
  logic             tx_q,      tx_nxt;
  logic             busy_q,    busy_nxt;
  logic             done_q,    done_nxt;

  logic             bit_end;
  logic [2:0]       bit_idx_inc;

  assign bit_end     = (cnt_q == CNT_LAST);
  assign bit_idx_inc = bit_idx_q + 3'd1;

  // State and output registers. Every output is a flop so the line level
  // for the next bit is computed one cycle ahead in the combinational block.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      bit_idx_q <= bit_idx_nxt;
      shift_q   <= shift_nxt;
      tx_q      <= tx_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q + CNT_W'(1);
    bit_idx_nxt = bit_idx_q;
    shift_nxt   = shift_q;
    tx_nxt      = tx_q;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = 1'b1;
        if (i_fStart) begin
          // Start bit goes out on this same edge.
          shift_nxt   = i_Data;
          bit_idx_nxt = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = ST_START;
        end
      end

      ST_START: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shift_q[0];
          state_nxt   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_nxt = '0;
`ifdef UART_TX_PARITY_EN
            tx_nxt    = ^shift_q;
            state_nxt = ST_PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_inc;
            tx_nxt      = shift_q[bit_idx_inc];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_end) begin
          // Back to IDLE for at least one cycle: this is the mandatory
          // one-clock high gap between back-to-back frames.
          cnt_nxt   = '0;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_Tx    = tx_q;
  assign o_fBusy = busy_q;
  assign o_fDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with CLKS_PER_BIT=4.
// Frame bit levels are written out by hand in time order (start, d0..d7, stop).
// Build with UART_TX_PARITY_EN to expect the parity slot and 44-cycle frames.

module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME = NSLOT * CPB;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_fStart (start),
    .i_Data   (data),
    .o_Tx     (tx),
    .o_fBusy  (busy),
    .o_fDone  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [7:0] d;
    logic [9:0] ef;   // line levels in time order, bit 9 first
    logic       ep;   // even parity of d
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic slot_level(input logic [9:0] ef, input logic ep, input int s);
`ifdef UART_TX_PARITY_EN
    if (s == 9)  return ep;
    if (s == 10) return 1'b1;
`else
    if (ep === 1'bx) return 1'b0;
`endif
    return ef[9 - s];
  endfunction

  // Called at the negedge following the accepting edge. Checks every cycle
  // of the frame, then the done cycle. If ign >= 0 a rogue request for 3C
  // is pulsed at that cycle.
  task automatic check_body(input logic [9:0] ef, input logic ep, input int ign, input string tag);
    for (int c = 0; c < FRAME; c++) begin
      if (c == ign) begin
        start = 1'b1;
        data  = 8'h3C;
      end else if (c == ign + 1) begin
        start = 1'b0;
      end
      chk($sformatf("%s tx c%0d", tag, c), 32'(tx), 32'(slot_level(ef, ep, c / CPB)));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s done c%0d", tag, c), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk($sformatf("%s done pulse", tag), 32'(done), 32'd1);
    chk($sformatf("%s busy end", tag), 32'(busy), 32'd0);
    chk($sformatf("%s tx end", tag), 32'(tx), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] ef, input logic ep, input int ign, input string tag);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    data  = ~d;   // must not disturb the frame in flight
    check_body(ef, ep, ign, tag);
    @(negedge clk);
    chk({tag, " done low after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{8'hA5, 10'b0101001011, 1'b0};
    vecs[1] = '{8'h81, 10'b0100000011, 1'b0};
    vecs[2] = '{8'h3C, 10'b0001111001, 1'b0};
    vecs[3] = '{8'h07, 10'b0111000001, 1'b1};
    vecs[4] = '{8'h03, 10'b0110000001, 1'b0};
    vecs[5] = '{8'h55, 10'b0101010101, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;

    // Reset held three cycles.
    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle tx c%0d", c), 32'(tx), 32'd1);
      chk($sformatf("idle busy c%0d", c), 32'(busy), 32'd0);
    end

    // Table-driven single frames.
    for (int i = 0; i < 6; i++)
      send(vecs[i].d, vecs[i].ef, vecs[i].ep, -10, $sformatf("vec%0d", i));

    // Back-to-back: start held high, 00 then FF, one idle cycle between.
    @(negedge clk);
    start = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    data  = 8'hFF;
    check_body(10'b0000000001, 1'b0, -10, "b2b0");
    @(negedge clk);
    start = 1'b0;
    check_body(10'b0111111111, 1'b0, -10, "b2b1");
    @(negedge clk);
    chk("b2b no third frame", 32'(busy), 32'd0);

    // Ignored request mid-frame.
    d0 = done_cnt;
    send(8'h81, 10'b0100000011, 1'b0, 10, "ign");
    for (int c = 0; c < 30; c++) begin
      chk($sformatf("ign idle tx c%0d", c), 32'(tx), 32'd1);
      @(negedge clk);
    end
    chk("ign busy", 32'(busy), 32'd0);
    chk("ign one done", 32'(done_cnt), 32'(d0 + 1));

    // Reset at cycle 17 of a 55 frame.
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 17; c++) begin
      chk($sformatf("rmid tx c%0d", c), 32'(tx), 32'(slot_level(10'b0101010101, 1'b0, c / CPB)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmid tx", 32'(tx), 32'd1);
    chk("rmid busy", 32'(busy), 32'd0);
    chk("rmid done", 32'(done), 32'd0);
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("rmid idle tx c%0d", c), 32'(tx), 32'd1);
      @(negedge clk);
    end
    chk("rmid no done", 32'(done_cnt), 32'(d0));
    send(8'h55, 10'b0101010101, 1'b0, -10, "rmid clean");

    // Reset and start on the same edge: reset wins.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("rst+start tx", 32'(tx), 32'd1);
    chk("rst+start busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst+start still idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter; counterpart of the UART receiver path. Serialises one byte per request onto the i_Rx-style serial line.
- Frame format: 8N1 by default.
- Sits between a byte source (switch bank, host logic, loopback from the receiver's data byte) and the board TX pin.
- Provides a start/busy/done handshake so upstream logic can stream bytes back-to-back.

Parameters:
- CLKS_PER_BIT, 434, number of i_Clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- i_Clk  input  1  system clock; all logic on the rising edge.
- i_Rst  input  1  synchronous, active-high reset; one clock domain only.
- i_fStart  input  1  request to send i_Data; sampled only in IDLE.
- i_Data  input  8  byte to transmit; captured on the accepting edge.
- o_Tx  output  1  serial line, idle high; registered.
- o_fBusy  output  1  high from the accepting edge until the frame ends.
- o_fDone  output  1  one-cycle pulse at end of stop bit; registered.

Behaviour:
- Reset (i_Rst=1 at a rising edge) sets o_Tx=1, o_fBusy=0, o_fDone=0, state=IDLE, baud counter=0, bit index=0, shift register=0. Reset overrides any in-progress frame; the line returns high on the next edge and the partial frame is abandoned.
- States:
  - IDLE: o_Tx=1. If i_fStart=1, latch i_Data into the shift register and go to START; o_fBusy=1 from that edge. Otherwise remain.
  - START: o_Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_Tx = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP (or PARITY if enabled).
  - STOP: o_Tx=1 for CLKS_PER_BIT cycles. On the last cycle go to IDLE, set o_fDone=1 for exactly one cycle and drop o_fBusy.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 within each bit and clears to 0 on every bit and state transition.
  - Transition occurs at the edge where the counter equals CLKS_PER_BIT-1.
- Latency:
  - o_Tx falls on the same edge that accepts i_fStart (registered output).
  - Full frame = 10*CLKS_PER_BIT cycles (11* with parity), measured from the accepting edge to the edge that raises o_fDone.
- Back-to-back transfers:
  - i_fStart held high continuously gives one frame, one idle cycle (the o_fDone cycle, IDLE), then the next frame.
  - The idle cycle is mandatory, so the gap is exactly 1 clock of high line between stop bit and next start bit.
- i_fStart while o_fBusy=1 is ignored; it is not queued. i_Data changes during a frame do not affect the frame in flight.
- i_Rst and i_fStart asserted together: reset wins and the request is dropped.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - o_Tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
- When undefined:
  - No PARITY state and no parity logic is synthesised.
  - Frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan:
- Reset: CLKS_PER_BIT=4, hold i_Rst=1 for 3 cycles -> o_Tx=1, o_fBusy=0, o_fDone=0; line stays high 20 cycles with i_fStart=0.
- Single byte: CLKS_PER_BIT=4, pulse i_fStart one cycle with i_Data=8'hA5 -> o_Tx sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 4 cycles. o_fBusy is high 40 cycles; o_fDone pulses once, 40 cycles after the accepting edge.
- Back-to-back: i_fStart held high, i_Data=8'h00 then 8'h FF -> two frames separated by exactly 1 high cycle. Second frame is 0, eight 1s, 1.
- Ignored request: pulse i_fStart with i_Data=8'h3C at cycle 10 of an 8'h81 frame -> 8'h81 frame unaltered; no second frame; one o_fDone only.
- Reset mid-frame: assert i_Rst at cycle 17 of an 8'h55 frame -> o_Tx=1 and o_fBusy=0 next edge; no o_fDone. A new i_fStart then sends a clean frame.
- Parity build (UART_TX_PARITY_EN defined): send 8'h07 -> parity bit 1; send 8'h03 -> parity bit 0. Each frame is 44 cycles with CLKS_PER_BIT=4.
